// File: rtl/cycle_sequencer.sv
// Instruction-cycle sequencer: steps FETCH/DECODE/EXECUTE/STORE, inserts memory
// wait states, owns the PC and retired count, and freezes on a stuck handshake.
module cycle_sequencer #(
  parameter int PC_WIDTH    = 16,
  parameter int RESET_PC    = 0,
  parameter int WAIT_LIMIT  = 255,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   instruction_enable,
  input  logic                   instruction_ready,
  input  logic                   read_enable,
  input  logic                   read_ready,
  input  logic                   write_enable,
  input  logic                   write_ready,
  input  logic                   jump_PC,
  input  logic                   branch_PC,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    target,
  output logic [1:0]             state,
  output logic [PC_WIDTH-1:0]    PC,
  output logic                   stall,
  output logic [COUNT_WIDTH-1:0] retired,
  output logic                   timeout
);

  typedef enum logic [1:0] {
    FETCH   = 2'b00,
    DECODE  = 2'b01,
    EXECUTE = 2'b10,
    STORE   = 2'b11
  } state_e;

  localparam logic [PC_WIDTH-1:0] RESET_PC_V = PC_WIDTH'(RESET_PC);
  localparam logic [15:0]         LIMIT_V    = 16'(WAIT_LIMIT);

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [COUNT_WIDTH-1:0] retired_q, retired_d;
  logic                   timeout_q, timeout_d;
  logic [15:0]            wait_cnt_q, wait_cnt_d;
  logic                   mem_wait;
  logic                   stall_c;
  logic                   store_exit;

  always_comb begin
    mem_wait   = (instruction_enable & ~instruction_ready) |
                 (read_enable & ~read_ready) |
                 (write_enable & ~write_ready);
    stall_c    = mem_wait | ((state_q == FETCH) & ~run) | timeout_q;
    store_exit = (state_q == STORE) & ~stall_c;

    state_d    = state_q;
    pc_d       = pc_q;
    retired_d  = retired_q;
    timeout_d  = timeout_q;
    wait_cnt_d = wait_cnt_q;

    if (!stall_c) begin
      unique case (state_q)
        FETCH:   state_d = DECODE;
        DECODE:  state_d = EXECUTE;
        EXECUTE: state_d = STORE;
        STORE:   state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end

    // Jump wins over branch; otherwise fall through to the next address.
    if (store_exit) begin
      if (jump_PC)
        pc_d = target;
      else if (branch_PC && branch_taken)
        pc_d = target;
      else
        pc_d = pc_q + PC_WIDTH'(1);
      retired_d = retired_q + COUNT_WIDTH'(1);
    end

    // A ready arriving while the counter sits at the limit still succeeds.
    if (!timeout_q) begin
      if (mem_wait) begin
        if (wait_cnt_q == LIMIT_V)
          timeout_d = 1'b1;
        else
          wait_cnt_d = wait_cnt_q + 16'd1;
      end else begin
        wait_cnt_d = 16'd0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC_V;
      retired_q  <= '0;
      timeout_q  <= 1'b0;
      wait_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      retired_q  <= retired_d;
      timeout_q  <= timeout_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign state   = state_q;
  assign PC      = pc_q;
  assign retired = retired_q;
  assign timeout = timeout_q;
  assign stall   = stall_c;

endmodule
